// File: rtl/alarm_ctrl.sv
// Alarm clock controller: alarm-time editing, arm/watch, ring with auto-stop and limited snooze.
// All outputs come straight from flops or from a decode of the state register.
module alarm_ctrl #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_snooze,
  input  logic       arm,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  output logic [4:0] alm_hour,
  output logic [5:0] alm_min,
  output logic [1:0] edit_sel,
  output logic       blink,
  output logic       ringing,
  output logic       led
);

  typedef enum logic [2:0] {
    StIdle, StEditMin, StEditHour, StWatch, StRing, StSnooze
  } state_e;

  localparam logic [8:0] RingLast = 9'(RING_SECS - 1);
  localparam logic [8:0] SnzLast  = 9'(SNOOZE_SECS - 1);
  localparam logic [2:0] SnzMax   = 3'(MAX_SNOOZE);

  state_e     state_q, state_d;
  logic [8:0] sec_q, sec_d;
  logic [2:0] snz_q, snz_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic       blink_q, blink_d;
  logic       led_q, led_d;
  logic       match;
  logic       in_edit_next;

  // Only the tick of second zero can trigger, so a given alarm time fires once per day.
  assign match = tick_1hz && (cur_hour == hour_q) && (cur_min == min_q) && (cur_sec == 6'd0);

  always_comb begin
    state_d = state_q;
    snz_d   = snz_q;
    hour_d  = hour_q;
    min_d   = min_q;
    unique case (state_q)
      StIdle: begin
        if (btn_set)  state_d = StEditMin;
        else if (arm) state_d = StWatch;
      end
      StEditMin: begin
        if (btn_set)      state_d = StEditHour;
        else if (btn_inc) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
      end
      StEditHour: begin
        if (btn_set)      state_d = StIdle;
        else if (btn_inc) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      end
      StWatch: begin
        if (!arm)         state_d = StIdle;
        else if (btn_set) state_d = StEditMin;
        else if (match) begin
          state_d = StRing;
          snz_d   = 3'd0;
        end
      end
      StRing: begin
        if (!arm)         state_d = StIdle;
        else if (btn_set) state_d = StWatch;
        else if (btn_snooze && (snz_q < SnzMax)) begin
          state_d = StSnooze;
          snz_d   = snz_q + 3'd1;
        end else if (tick_1hz && (sec_q == RingLast)) state_d = StWatch;
      end
      StSnooze: begin
        if (!arm)                                 state_d = StIdle;
        else if (btn_set)                         state_d = StWatch;
        else if (tick_1hz && (sec_q == SnzLast)) state_d = StRing;
      end
      default: state_d = StIdle;
    endcase

    // Counter restarts on every state change; it simply runs in states that ignore it.
    if (state_d != state_q) sec_d = 9'd0;
    else                    sec_d = tick_1hz ? sec_q + 9'd1 : sec_q;

    in_edit_next = (state_d == StEditMin) || (state_d == StEditHour);
    blink_d = 1'b0;
    if (in_edit_next && (state_d == state_q)) blink_d = blink_q ^ tick_1hz;

    led_d = 1'b0;
    if (state_d == StRing) led_d = (state_q != StRing) ? 1'b1 : (led_q ^ tick_1hz);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sec_q   <= 9'd0;
      snz_q   <= 3'd0;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      blink_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      snz_q   <= snz_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  assign alm_hour = hour_q;
  assign alm_min  = min_q;
  assign blink    = blink_q;
  assign led      = led_q;
  assign ringing  = (state_q == StRing);
  assign edit_sel = (state_q == StEditMin)  ? 2'b01 :
                    (state_q == StEditHour) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: countdown-style reference model checked every cycle, plus literal checks.
module tb_alarm_ctrl;

  localparam int RS = 4;
  localparam int SS = 2;
  localparam int MS = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, btn_set = 1'b0, btn_inc = 1'b0, btn_snooze = 1'b0, arm = 1'b0;
  logic [4:0] cur_hour = 5'd0;
  logic [5:0] cur_min = 6'd0, cur_sec = 6'd0;
  logic [4:0] alm_hour;
  logic [5:0] alm_min;
  logic [1:0] edit_sel;
  logic       blink, ringing, led;

  int total = 0;
  int bad = 0;
  bit run_chk = 1'b0;

  // Model: mode 0 idle, 1 edit min, 2 edit hour, 3 watch, 4 ring, 5 snooze.
  int m_mode, m_hour, m_min, m_left, m_used, m_led, m_blink;

  always #5 clk = ~clk;

  alarm_ctrl #(.RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MS)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_set(btn_set), .btn_inc(btn_inc),
    .btn_snooze(btn_snooze), .arm(arm), .cur_hour(cur_hour), .cur_min(cur_min),
    .cur_sec(cur_sec), .alm_hour(alm_hour), .alm_min(alm_min), .edit_sel(edit_sel),
    .blink(blink), .ringing(ringing), .led(led)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hour = 0; m_min = 0; m_left = 0; m_used = 0; m_led = 0; m_blink = 0;
  endtask

  task automatic model_step();
    int nxt;
    nxt = m_mode;
    case (m_mode)
      0: if (btn_set) nxt = 1; else if (arm) nxt = 3;
      1: if (btn_set) nxt = 2; else if (btn_inc) m_min = (m_min + 1) % 60;
      2: if (btn_set) nxt = 0; else if (btn_inc) m_hour = (m_hour + 1) % 24;
      3: begin
        if (!arm) nxt = 0;
        else if (btn_set) nxt = 1;
        else if (tick_1hz && cur_hour == m_hour && cur_min == m_min && cur_sec == 0) begin
          nxt = 4; m_used = 0;
        end
      end
      4: begin
        if (!arm) nxt = 0;
        else if (btn_set) nxt = 3;
        else if (btn_snooze && m_used < MS) begin nxt = 5; m_used++; end
        else if (tick_1hz) begin if (m_left == 1) nxt = 3; else m_left--; end
      end
      5: begin
        if (!arm) nxt = 0;
        else if (btn_set) nxt = 3;
        else if (tick_1hz) begin if (m_left == 1) nxt = 4; else m_left--; end
      end
      default: nxt = 0;
    endcase
    if (nxt == 4 && m_mode != 4) m_left = RS;
    else if (nxt == 5 && m_mode != 5) m_left = SS;
    if (nxt == 4) m_led = (m_mode != 4) ? 1 : (tick_1hz ? 1 - m_led : m_led);
    else m_led = 0;
    if ((nxt == 1 || nxt == 2) && nxt == m_mode) begin
      if (tick_1hz) m_blink = 1 - m_blink;
    end else m_blink = 0;
    m_mode = nxt;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (run_chk && !rst) begin
      chk("m_alm_hour", int'(alm_hour), m_hour);
      chk("m_alm_min", int'(alm_min), m_min);
      chk("m_edit_sel", int'(edit_sel), (m_mode == 1) ? 1 : (m_mode == 2) ? 2 : 0);
      chk("m_blink", int'(blink), m_blink);
      chk("m_ringing", int'(ringing), (m_mode == 4) ? 1 : 0);
      chk("m_led", int'(led), m_led);
    end
  end

  // One clock of stimulus; returns just after the edge so outputs can be read.
  task automatic step(input logic t, input logic s, input logic i, input logic z);
    @(negedge clk);
    tick_1hz = t; btn_set = s; btn_inc = i; btn_snooze = z;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; btn_set = 1'b0; btn_inc = 1'b0; btn_snooze = 1'b0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_chk = 1'b1;
    #1;
    chk("rst_ringing", int'(ringing), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_alm", int'({alm_hour, alm_min}), 0);
    chk("rst_edit_sel", int'(edit_sel), 0);

    // Edit wrap: 61 minute increments, 25 hour increments
    step(0, 1, 0, 0);
    chk("edit_sel_min", int'(edit_sel), 1);
    for (int k = 0; k < 61; k++) step((k % 10) == 3, 0, 1, 0);
    step(0, 1, 0, 0);
    chk("edit_sel_hour", int'(edit_sel), 2);
    for (int k = 0; k < 25; k++) step((k % 7) == 2, 0, 1, 0);
    step(0, 1, 0, 0);
    chk("wrap_min", int'(alm_min), 1);
    chk("wrap_hour", int'(alm_hour), 1);
    chk("wrap_edit_sel", int'(edit_sel), 0);
    step(0, 0, 0, 0);

    // Program 7:30
    step(0, 1, 0, 0);
    for (int k = 0; k < 29; k++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    chk("prog_alm", int'(alm_hour) * 100 + int'(alm_min), 730);

    // Trigger and auto-stop
    arm = 1'b1;
    step(0, 0, 0, 0);
    set_cur(7, 29, 59); step(1, 0, 0, 0);
    chk("early_no_ring", int'(ringing), 0);
    set_cur(7, 30, 0); step(1, 0, 0, 0);
    chk("trig_ringing", int'(ringing), 1);
    chk("trig_led", int'(led), 1);
    set_cur(7, 30, 1); step(1, 0, 0, 0);
    chk("led_t1", int'(led), 0);
    set_cur(7, 30, 2); step(1, 0, 0, 0);
    chk("led_t2", int'(led), 1);
    set_cur(7, 30, 3); step(1, 0, 0, 0);
    chk("led_t3", int'(led), 0);
    chk("ring_t3", int'(ringing), 1);
    set_cur(7, 30, 4); step(1, 0, 0, 0);
    chk("autostop_ringing", int'(ringing), 0);
    chk("autostop_led", int'(led), 0);
    set_cur(7, 30, 5); step(1, 0, 0, 0);
    chk("no_retrigger", int'(ringing), 0);

    // Snooze limit
    set_cur(7, 30, 0); step(1, 0, 0, 0);
    chk("ring2", int'(ringing), 1);
    set_cur(7, 30, 1); step(0, 0, 0, 1);
    chk("snooze_off", int'(ringing), 0);
    step(1, 0, 0, 0);
    chk("snooze_t1", int'(ringing), 0);
    step(1, 0, 0, 0);
    chk("snooze_back", int'(ringing), 1);
    chk("snooze_back_led", int'(led), 1);
    step(0, 0, 0, 1);
    chk("snooze_limit", int'(ringing), 1);

    // Priority: set beats snooze, arm=0 beats set
    step(0, 1, 0, 1);
    chk("prio_watch", int'(ringing), 0);
    chk("prio_watch_led", int'(led), 0);
    set_cur(7, 30, 0); step(1, 0, 0, 0);
    chk("ring3", int'(ringing), 1);
    arm = 1'b0;
    step(0, 1, 0, 1);
    chk("prio_idle", int'(ringing), 0);
    chk("prio_idle_sel", int'(edit_sel), 0);
    step(1, 0, 0, 0);

    // Async reset mid-RING
    arm = 1'b1;
    step(0, 0, 0, 0);
    set_cur(7, 30, 0); step(1, 0, 0, 0);
    chk("ring4", int'(ringing), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_ringing", int'(ringing), 0);
    chk("arst_led", int'(led), 0);
    chk("arst_alm", int'(alm_hour) * 100 + int'(alm_min), 0);
    #1 rst = 1'b0;
    step(0, 0, 0, 0);
    chk("post_rst_ringing", int'(ringing), 0);

    // Async reset mid-edit
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_edit_sel", int'(edit_sel), 0);
    chk("arst_edit_min", int'(alm_min), 0);
    #1 rst = 1'b0;
    repeat (3) step(1, 0, 0, 0);

    @(negedge clk);
    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
